jk_bank_sequencer: RTL and testbench
====================================

Name: jk_bank_sequencer

Overview:
Command-driven controller for a bank of N_FF JK flip-flop cells. It accepts one command per valid/ready handshake: HOLD, CLR, SET or TOGGLE, a target cell index and a repeat count. It then sequences the J/K inputs of the selected cell for the requested number of clock edges and pulses done on completion. It sits between a host or test FSM and the JK storage bank, and it is the only driver of the bank's J/K lines.

Parameters:
N_FF, 8, number of JK cells in the bank
IDX_W, 3, width of cmd_idx; must satisfy 2**IDX_W >= N_FF
CNT_W, 4, width of cmd_count (repeat count)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  {J,K} encoding: 00 HOLD, 01 CLR, 10 SET, 11 TOGGLE
cmd_idx  in  IDX_W  target cell index
cmd_count  in  CNT_W  number of applications; 0 is treated as 1
busy  out  1  command in progress (APPLY or DONE)
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done when cmd_idx >= N_FF
j  out  N_FF  J inputs driven into the bank (observability)
k  out  N_FF  K inputs driven into the bank (observability)
q  out  N_FF  Q outputs of the bank

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - state=IDLE; all q=0; done=0; err=0; busy=0; cmd_ready=1 in the following cycle.
  - Latched command fields are cleared.
- Handshake:
  - Transfer occurs on an edge where cmd_valid && cmd_ready.
  - The transfer latches op, idx and count (count 0 is latched as 1), and the FSM moves IDLE->APPLY.
  - cmd_* inputs are ignored while cmd_ready=0. cmd_valid may be held high; no skid buffer is provided.
- FSM states: IDLE, APPLY, DONE.
  - IDLE: cmd_ready=1, busy=0, j=k=0.
  - APPLY: busy=1. j[idx]=op[1] and k[idx]=op[0]; all other bits 0. An internal remaining-count decrements each cycle. When it reaches 1, the next state is DONE.
  - DONE: done=1 and busy=1 for exactly one cycle; j=k=0; next state IDLE.
- Timing:
  - Accept at edge t0; first q update at edge t1; last q update at edge tn (n = effective count).
  - done is high in the cycle between tn and tn+1. cmd_ready returns after edge tn+1.
  - Throughput is one command per n+2 cycles.
- Cell semantics, per the JK truth table:
  - 00 holds; 01 forces Q=0; 10 forces Q=1; 11 inverts Q.
  - Repeated SET/CLR/HOLD is idempotent. TOGGLE with odd n ends inverted; with even n it ends unchanged.
- Out-of-range idx (idx >= N_FF):
  - The command is accepted and the FSM passes through APPLY for n cycles with all j=k=0, so no q changes.
  - err pulses together with done.
- Counter width: the remaining-count register is CNT_W bits. Maximum count 2**CNT_W-1 gives that many applications; there is no wrap.
- Reset mid-operation: rst in APPLY or DONE aborts immediately. The next state is IDLE, all q=0, and done/err are not asserted for the aborted command.
- Unselected cells never see a nonzero J or K.

Decomposition:
- Shared package:
  - op encoding constants OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TOG=2'b11.
  - FSM state encoding ST_IDLE, ST_APPLY, ST_DONE.
- Sub-module jk_cell:
  - Ports clk, rst, J, K, Q; synchronous active-high reset to Q=0.
  - Instantiated N_FF times via generate. The controller FSM and decode stay in jk_bank_sequencer.

Test Plan:
- Reset: hold rst=1 for 2 cycles with cmd_valid=1 -> q=8'h00, cmd_ready=1, busy=0, done=0 after release, and no command accepted during reset.
- SET idx=2, count=0: accept at t0 -> q=8'h04 after t1, done pulse between t1 and t2, cmd_ready=1 after t2. Then CLR idx=2 -> q=8'h00.
- TOGGLE idx=0, count=3 from q=0 -> q[0] sequence 1,0,1 on edges t1..t3, done after t3, final q=8'h01. Repeat with count=4 -> final q[0] unchanged.
- Back-to-back: cmd_valid held high with SET idx=7, then TOGGLE idx=7 -> second transfer only on the edge after done. Final q[7]=0, and exactly 2 done pulses.
- Out-of-range: N_FF=6, IDX_W=3, SET idx=6, count=2 -> q unchanged, j=k=0 throughout, done and err both high for one cycle at t3.
- Reset mid-burst: TOGGLE idx=1, count=10, assert rst at cycle 4 -> q=0, state IDLE, no done or err pulse, next command accepted normally.

Source files
------------

// File: rtl/jk_bank_sequencer_pkg.sv
// Shared encodings for the JK bank sequencer: command ops and controller states.
package jk_bank_sequencer_pkg;

  // Op encoding is {J,K}, so bit 1 drives J and bit 0 drives K directly.
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with synchronous active-high reset.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b00:   Q <= Q;
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        default: Q <= ~Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller that sequences J/K into one cell of a JK bank
// for a requested number of clock edges, then pulses done (and err if out of range).
module jk_bank_sequencer
  import jk_bank_sequencer_pkg::*;
#(
  parameter int N_FF  = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N_FF-1:0]  j,
  output logic [N_FF-1:0]  k,
  output logic [N_FF-1:0]  q
);

  state_t           state_reg;
  logic [CNT_W-1:0] rem_reg;
  logic             oob_reg;
  logic [N_FF-1:0]  j_reg;
  logic [N_FF-1:0]  k_reg;
  logic             cmd_ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;
  logic [N_FF-1:0]  sel;

  // An out-of-range index matches no cell, so its decoded J/K stay all-zero.
  generate
    for (genvar gi = 0; gi < N_FF; gi++) begin : g_cell
      assign sel[gi] = (cmd_idx == IDX_W'(gi));

      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .J   (j_reg[gi]),
        .K   (k_reg[gi]),
        .Q   (q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rem_reg       <= '0;
      oob_reg       <= 1'b0;
      j_reg         <= '0;
      k_reg         <= '0;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_reg) begin
            state_reg     <= ST_APPLY;
            rem_reg       <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
            oob_reg       <= (32'(cmd_idx) >= N_FF);
            j_reg         <= cmd_op[1] ? sel : '0;
            k_reg         <= cmd_op[0] ? sel : '0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end
        ST_APPLY: begin
          if (rem_reg == CNT_W'(1)) begin
            state_reg <= ST_DONE;
            j_reg     <= '0;
            k_reg     <= '0;
            done_reg  <= 1'b1;
            err_reg   <= oob_reg;
          end else begin
            rem_reg <= rem_reg - 1'b1;
          end
        end
        ST_DONE: begin
          state_reg     <= ST_IDLE;
          rem_reg       <= '0;
          oob_reg       <= 1'b0;
          done_reg      <= 1'b0;
          err_reg       <= 1'b0;
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= ST_IDLE;
          j_reg         <= '0;
          k_reg         <= '0;
          done_reg      <= 1'b0;
          err_reg       <= 1'b0;
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign j         = j_reg;
  assign k         = k_reg;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench: vector table + completion scoreboard on an 8-cell bank,
// plus hand sequences for back-to-back, out-of-range (6-cell bank) and mid-burst reset.
module tb_jk_bank_sequencer;
  import jk_bank_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_idx;
  logic [3:0] cmd_count;
  logic       busy, done, err;
  logic [7:0] j, k, q;

  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_op;
  logic [2:0] b_idx;
  logic [3:0] b_cnt;
  logic       b_busy, b_done, b_err;
  logic [5:0] b_j, b_k, b_q;

  always #5 clk = ~clk;

  jk_bank_sequencer #(.N_FF(8), .IDX_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_count(cmd_count),
    .busy(busy), .done(done), .err(err), .j(j), .k(k), .q(q)
  );

  jk_bank_sequencer #(.N_FF(6), .IDX_W(3), .CNT_W(4)) dut6 (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_idx(b_idx), .cmd_count(b_cnt),
    .busy(b_busy), .done(b_done), .err(b_err), .j(b_j), .k(b_k), .q(b_q)
  );

  typedef struct {
    logic [1:0] op;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [7:0] exp_q;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  logic qtrace[64];
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done on the 8-cell bank must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 q=%0h expected no done", q);
      end else begin
        e = sb_q.pop_front();
        chk("sb_final_q", 32'(q), 32'(e.q));
        chk("sb_err", 32'(err), 32'(e.err));
        $display("done: q=%02h err=%0b", q, err);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] cnt,
                       input logic [7:0] exp_q);
    int n, t, lat;
    logic [7:0] onehot;
    exp_t e;
    n = (cnt == 0) ? 1 : int'(cnt);
    onehot = 8'h01 << idx;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_count = cnt;
    e.q = exp_q;
    e.err = 1'b0;
    sb_q.push_back(e);
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("j_apply", 32'(j), op[1] ? 32'(onehot) : 32'd0);
    chk("k_apply", 32'(k), op[0] ? 32'(onehot) : 32'd0);
    lat = 1;
    qtrace[1] = q[0];
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      qtrace[lat] = q[0];
    end
    chk("done_latency", 32'(lat), 32'(n + 1));
    @(negedge clk);
    chk("idle_after_done", {29'd0, done, busy, cmd_ready}, 32'b001);
    $display("cmd op=%0d idx=%0d cnt=%0d -> q=%02h latency=%0d", op, idx, cnt, q, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{OP_SET,  3'd2, 4'd0,  8'h04};
    vecs[1] = '{OP_CLR,  3'd2, 4'd1,  8'h00};
    vecs[2] = '{OP_TOG,  3'd0, 4'd3,  8'h01};
    vecs[3] = '{OP_TOG,  3'd0, 4'd4,  8'h01};
    vecs[4] = '{OP_SET,  3'd5, 4'd15, 8'h21};
    vecs[5] = '{OP_HOLD, 3'd5, 4'd2,  8'h21};
    vecs[6] = '{OP_TOG,  3'd3, 4'd1,  8'h29};
    vecs[7] = '{OP_CLR,  3'd0, 4'd2,  8'h28};
    vecs[8] = '{OP_TOG,  3'd7, 4'd2,  8'h28};

    // Reset held with a command offered: nothing may be accepted.
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_idx = 3'd0; cmd_count = 4'd1;
    b_valid = 1'b1; b_op = OP_SET; b_idx = 3'd0; b_cnt = 4'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    b_valid = 1'b0;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_flags", {28'd0, done, err, busy, cmd_ready}, 32'b0001);
    @(negedge clk);
    chk("reset_no_accept", {30'd0, busy, cmd_ready}, 32'b01);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].idx, vecs[i].cnt, vecs[i].exp_q);
      if (i == 2) begin
        chk("tog3_trace", {29'd0, qtrace[2], qtrace[3], qtrace[4]}, 32'b101);
      end
    end

    // Back-to-back with cmd_valid held high: second transfer waits for IDLE.
    base = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_idx = 3'd7; cmd_count = 4'd1;
    sb_q.push_back('{q: 8'ha8, err: 1'b0});
    @(negedge clk);
    cmd_op = OP_TOG;
    sb_q.push_back('{q: 8'h28, err: 1'b0});
    chk("b2b_apply1", {30'd0, busy, cmd_ready}, 32'b10);
    @(negedge clk);
    chk("b2b_done1", {30'd0, done, cmd_ready}, 32'b10);
    @(negedge clk);
    chk("b2b_idle_gap", {30'd0, busy, cmd_ready}, 32'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_apply2_jk", {16'd0, j, k}, {16'd0, 8'h80, 8'h80});
    @(negedge clk);
    chk("b2b_done2_q", 32'(q), 32'h28);
    @(negedge clk);
    chk("b2b_done_count", 32'(done_cnt - base), 32'd2);
    $display("b2b: q=%02h done pulses=%0d", q, done_cnt - base);

    // Out-of-range index on the 6-cell bank.
    @(negedge clk);
    b_valid = 1'b1; b_op = OP_SET; b_idx = 3'd6; b_cnt = 4'd2;
    @(negedge clk);
    b_valid = 1'b0;
    chk("oob_apply1", {18'd0, b_j, b_k, b_busy, b_done}, {18'd0, 12'd0, 2'b10});
    @(negedge clk);
    chk("oob_apply2", {19'd0, b_j, b_k, b_done}, 32'd0);
    @(negedge clk);
    chk("oob_done_err", {30'd0, b_done, b_err}, 32'b11);
    chk("oob_q", {14'd0, b_q, b_j, b_k}, 32'd0);
    @(negedge clk);
    chk("oob_after", {29'd0, b_done, b_err, b_ready}, 32'b001);
    b_valid = 1'b1; b_op = OP_SET; b_idx = 3'd5; b_cnt = 4'd1;
    @(negedge clk);
    b_valid = 1'b0;
    chk("n6_set5_j", 32'(b_j), 32'h20);
    @(negedge clk);
    chk("n6_set5_done", {24'd0, b_q, b_done, b_err}, {24'd0, 6'h20, 2'b10});
    $display("oob: n6 q=%02h", b_q);

    // Reset in the middle of a 10-edge toggle burst.
    base = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_TOG; cmd_idx = 3'd1; cmd_count = 4'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_flags", {28'd0, done, err, busy, cmd_ready}, 32'b0001);
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - base), 32'd0);
    $display("abort: q=%02h", q);
    issue(OP_SET, 3'd1, 4'd1, 8'h02);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
